// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the accumulator CPU controller: states, opcodes, sub-ops, ALU codes, mux selects.
// Pure declarations, no latency or backpressure.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH0,
        S_DECODE,
        S_FETCH1,
        S_LD,
        S_ST_RD,
        S_ST_WR,
        S_ALU_RD,
        S_ALU_WB,
        S_JUMP,
        S_MISC,
        S_INC_EX,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_LDA  = 3'b000;
    localparam logic [2:0] OP_STA  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_JZ   = 3'b101;
    localparam logic [2:0] OP_JN   = 3'b110;
    localparam logic [2:0] OP_MISC = 3'b111;

    localparam logic [1:0] SUB_NOP = 2'b00;
    localparam logic [1:0] SUB_HLT = 2'b01;
    localparam logic [1:0] SUB_INC = 2'b10;
    localparam logic [1:0] SUB_RSV = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_INC = 3'b010;

    localparam logic [1:0] SEL_DATA_MEM  = 2'b00;
    localparam logic [1:0] SEL_DATA_RES  = 2'b01;
    localparam logic [1:0] SEL_DATA_DREG = 2'b10;
    localparam logic [1:0] SEL_AC_DI     = 2'b00;

    // Branches only ever look at the latched flags, never the live ALU outputs.
    function automatic logic branch_taken(input logic [2:0] op, input logic zf, input logic nf);
        case (op)
            OP_JMP:  branch_taken = 1'b1;
            OP_JZ:   branch_taken = zf;
            OP_JN:   branch_taken = nf;
            default: branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_ctrl_flags.sv
// Architectural carry/zero/negative flags, each captured from the ALU when its enable is high.
// One-cycle update latency; no backpressure.
module cpu_ctrl_flags (
    input  logic clk,
    input  logic reset,
    input  logic c_in,
    input  logic z_in,
    input  logic n_in,
    input  logic c_en,
    input  logic z_en,
    input  logic n_en,
    output logic cf,
    output logic zf,
    output logic nf
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cf <= 1'b0;
            zf <= 1'b0;
            nf <= 1'b0;
        end else begin
            if (c_en) cf <= c_in;
            if (z_en) zf <= z_in;
            if (n_en) nf <= n_in;
        end
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle Moore controller for the accumulator CPU datapath; CU_RETIRE_CNT_EN adds retireCount.
// Latency 3-5 cycles per instruction; no backpressure, strobes are issued unconditionally.
module cpu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter bit TRAP_RESERVED = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] toCU,
    input  logic [1:0] jmpCond,
    input  logic       CC,
    input  logic       ZZ,
    input  logic       NN,
    output logic       pcEn,
    output logic       selPC,
    output logic       selAddress,
    output logic       mr,
    output logic       mw,
    output logic       LSEn,
    output logic       RSEn,
    output logic       DIEn,
    output logic       wordRegEn,
    output logic       selALUsrc,
    output logic       enb,
    output logic       dataRegEn,
    output logic       resultRegEn,
    output logic       CEn,
    output logic       ZEn,
    output logic       NEn,
    output logic [1:0] selAddressAC,
    output logic [1:0] selData,
    output logic [2:0] operation,
    output logic       halted
`ifdef CU_RETIRE_CNT_EN
    ,
    output logic [15:0] retireCount
`endif
);

    state_t     state;
    state_t     next_state;
    logic [2:0] op_q;
    logic       cf;
    logic       zf;
    logic       nf;
    logic       unused;

    // Carry is architectural state but no branch tests it; toCU[0] is an address bit.
    assign unused       = ^{toCU[0], cf};
    assign wordRegEn    = 1'b0;
    assign selAddressAC = SEL_AC_DI;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RST;
            op_q  <= OP_LDA;
        end else begin
            state <= next_state;
            if (state == S_FETCH0) op_q <= toCU[3:1];
        end
    end

    cpu_ctrl_flags u_flags (
        .clk   (clk),
        .reset (reset),
        .c_in  (CC),
        .z_in  (ZZ),
        .n_in  (NN),
        .c_en  (CEn),
        .z_en  (ZEn),
        .n_en  (NEn),
        .cf    (cf),
        .zf    (zf),
        .nf    (nf)
    );

    always_comb begin
        next_state  = state;
        pcEn        = 1'b0;
        selPC       = 1'b0;
        selAddress  = 1'b0;
        mr          = 1'b0;
        mw          = 1'b0;
        LSEn        = 1'b0;
        RSEn        = 1'b0;
        DIEn        = 1'b0;
        selALUsrc   = 1'b0;
        enb         = 1'b0;
        dataRegEn   = 1'b0;
        resultRegEn = 1'b0;
        CEn         = 1'b0;
        ZEn         = 1'b0;
        NEn         = 1'b0;
        selData     = SEL_DATA_MEM;
        operation   = ALU_ADD;
        halted      = 1'b0;

        case (state)
            S_RST: next_state = S_FETCH0;
            S_FETCH0: begin
                mr         = 1'b1;
                LSEn       = 1'b1;
                pcEn       = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                DIEn       = 1'b1;
                next_state = (op_q == OP_MISC) ? S_MISC : S_FETCH1;
            end
            S_FETCH1: begin
                mr   = 1'b1;
                RSEn = 1'b1;
                pcEn = 1'b1;
                case (op_q)
                    OP_LDA:         next_state = S_LD;
                    OP_STA:         next_state = S_ST_RD;
                    OP_ADD, OP_AND: next_state = S_ALU_RD;
                    OP_JMP, OP_JZ,
                    OP_JN:          next_state = S_JUMP;
                    default:        next_state = S_FETCH0;
                endcase
            end
            S_LD: begin
                selAddress = 1'b1;
                mr         = 1'b1;
                selData    = SEL_DATA_MEM;
                enb        = 1'b1;
                next_state = S_FETCH0;
            end
            S_ST_RD: begin
                dataRegEn  = 1'b1;
                next_state = S_ST_WR;
            end
            S_ST_WR: begin
                selAddress = 1'b1;
                mw         = 1'b1;
                next_state = S_FETCH0;
            end
            S_ALU_RD: begin
                selAddress  = 1'b1;
                mr          = 1'b1;
                selALUsrc   = 1'b1;
                resultRegEn = 1'b1;
                ZEn         = 1'b1;
                NEn         = 1'b1;
                // AND leaves carry untouched.
                if (op_q == OP_ADD) begin
                    operation = ALU_ADD;
                    CEn       = 1'b1;
                end else begin
                    operation = ALU_AND;
                end
                next_state = S_ALU_WB;
            end
            S_ALU_WB: begin
                selData    = SEL_DATA_RES;
                enb        = 1'b1;
                next_state = S_FETCH0;
            end
            S_JUMP: begin
                selPC      = 1'b1;
                pcEn       = branch_taken(op_q, zf, nf);
                next_state = S_FETCH0;
            end
            S_MISC: begin
                case (jmpCond)
                    SUB_NOP: next_state = S_FETCH0;
                    SUB_HLT: next_state = S_HALT;
                    SUB_INC: begin
                        dataRegEn  = 1'b1;
                        next_state = S_INC_EX;
                    end
                    default: next_state = TRAP_RESERVED ? S_HALT : S_FETCH0;
                endcase
            end
            S_INC_EX: begin
                selALUsrc   = 1'b0;
                operation   = ALU_INC;
                resultRegEn = 1'b1;
                CEn         = 1'b1;
                ZEn         = 1'b1;
                NEn         = 1'b1;
                next_state  = S_ALU_WB;
            end
            S_HALT: halted = 1'b1;
            default: next_state = S_RST;
        endcase
    end

`ifdef CU_RETIRE_CNT_EN
    logic retire;

    // RST -> FETCH0 is a restart, not a retirement.
    assign retire = ((next_state == S_FETCH0) && (state != S_RST)) ||
                    ((next_state == S_HALT) && (state != S_HALT));

    always_ff @(posedge clk) begin
        if (reset) begin
            retireCount <= 16'd0;
        end else if (retire) begin
            retireCount <= retireCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboarded bench for cpu_control_unit: an instruction-level model queues per-cycle strobe expectations.
// A negedge monitor pops and compares them against the DUT outputs.
module tb_cpu_control_unit;

    localparam bit TRAP = 1'b1;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] toCU;
    logic [1:0] jmpCond;
    logic       CC, ZZ, NN;
    logic       pcEn, selPC, selAddress, mr, mw, LSEn, RSEn, DIEn, wordRegEn;
    logic       selALUsrc, enb, dataRegEn, resultRegEn, CEn, ZEn, NEn;
    logic [1:0] selAddressAC, selData;
    logic [2:0] operation;
    logic       halted;
`ifdef CU_RETIRE_CNT_EN
    logic [15:0] retireCount;
`endif

    cpu_control_unit #(.TRAP_RESERVED(TRAP)) dut (
        .clk(clk), .reset(reset), .toCU(toCU), .jmpCond(jmpCond),
        .CC(CC), .ZZ(ZZ), .NN(NN),
        .pcEn(pcEn), .selPC(selPC), .selAddress(selAddress), .mr(mr), .mw(mw),
        .LSEn(LSEn), .RSEn(RSEn), .DIEn(DIEn), .wordRegEn(wordRegEn),
        .selALUsrc(selALUsrc), .enb(enb), .dataRegEn(dataRegEn),
        .resultRegEn(resultRegEn), .CEn(CEn), .ZEn(ZEn), .NEn(NEn),
        .selAddressAC(selAddressAC), .selData(selData), .operation(operation),
        .halted(halted)
`ifdef CU_RETIRE_CNT_EN
        , .retireCount(retireCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcEn, selPC, selAddress, mr, mw, LSEn, RSEn, DIEn, wordRegEn;
        logic       selALUsrc, enb, dataRegEn, resultRegEn, CEn, ZEn, NEn;
        logic [1:0] selAddressAC;
        logic [1:0] selData;
        logic [2:0] operation;
        logic       halted;
    } outs_t;

    typedef struct {
        outs_t       o;
        logic [15:0] rc;
        string       tag;
    } exp_t;

    outs_t act;
    assign act = {pcEn, selPC, selAddress, mr, mw, LSEn, RSEn, DIEn, wordRegEn,
                  selALUsrc, enb, dataRegEn, resultRegEn, CEn, ZEn, NEn,
                  selAddressAC, selData, operation, halted};

    exp_t        exp_q[$];
    exp_t        mon_x;
    int          checks   = 0;
    int          failures = 0;
    int          cyc_n    = 0;
    logic        mz, mn;
    logic [15:0] mrc;
    logic        h;

    function automatic logic [3:0] rt(); return 4'($urandom); endfunction
    function automatic logic [1:0] rj(); return 2'($urandom); endfunction
    function automatic logic [2:0] rf(); return 3'($urandom); endfunction

    // One controller cycle: drive inputs for the cycle and queue its expected strobes.
    task automatic cyc(input outs_t e, input logic [3:0] t, input logic [1:0] j,
                       input logic [2:0] f, input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        toCU    = t;
        jmpCond = j;
        {CC, ZZ, NN} = f;
        x.o   = e;
        x.rc  = mrc;
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    task automatic do_reset(input int n);
        outs_t e;
        e      = '0;
        reset  = 1'b1;
        mz     = 1'b0;
        mn     = 1'b0;
        mrc    = 16'd0;
        repeat (n) cyc(e, rt(), rj(), rf(), "reset");
        reset = 1'b0;
    endtask

    task automatic hold_halt(input int n);
        outs_t e;
        e        = '0;
        e.halted = 1'b1;
        repeat (n) cyc(e, rt(), rj(), rf(), "halt");
    endtask

    task automatic fetch_byte0(input logic [2:0] op);
        outs_t e;
        e = '0; e.mr = 1'b1; e.LSEn = 1'b1; e.pcEn = 1'b1;
        cyc(e, {op, 1'($urandom)}, rj(), rf(), "fetch0");
        e = '0; e.DIEn = 1'b1;
        cyc(e, rt(), rj(), rf(), "decode");
    endtask

    task automatic fetch_byte1();
        outs_t e;
        e = '0; e.mr = 1'b1; e.RSEn = 1'b1; e.pcEn = 1'b1;
        cyc(e, rt(), rj(), rf(), "fetch1");
    endtask

    // Instruction-level model: strobe sequence from the ISA, flags from what the ALU reported.
    task automatic exec(input logic [2:0] op, input logic [1:0] sub, input logic [2:0] fl,
                        output logic halt_o);
        outs_t e;
        halt_o = 1'b0;
        fetch_byte0(op);
        if (op != 3'b111) begin
            fetch_byte1();
            case (op)
                3'b000: begin
                    e = '0; e.selAddress = 1'b1; e.mr = 1'b1; e.enb = 1'b1; e.selData = 2'b00;
                    cyc(e, rt(), rj(), rf(), "lda");
                end
                3'b001: begin
                    e = '0; e.dataRegEn = 1'b1;
                    cyc(e, rt(), rj(), rf(), "st_rd");
                    e = '0; e.selAddress = 1'b1; e.mw = 1'b1;
                    cyc(e, rt(), rj(), rf(), "st_wr");
                end
                3'b010, 3'b011: begin
                    e = '0; e.selAddress = 1'b1; e.mr = 1'b1; e.selALUsrc = 1'b1;
                    e.resultRegEn = 1'b1; e.ZEn = 1'b1; e.NEn = 1'b1;
                    e.CEn = (op == 3'b010);
                    e.operation = (op == 3'b010) ? 3'b000 : 3'b001;
                    cyc(e, rt(), rj(), fl, "alu_rd");
                    mz = fl[1];
                    mn = fl[0];
                    e = '0; e.selData = 2'b01; e.enb = 1'b1;
                    cyc(e, rt(), rj(), rf(), "alu_wb");
                end
                default: begin
                    e = '0; e.selPC = 1'b1;
                    e.pcEn = (op == 3'b100) || (op == 3'b101 && mz) || (op == 3'b110 && mn);
                    cyc(e, rt(), rj(), rf(), "jump");
                end
            endcase
        end else begin
            e = '0; e.dataRegEn = (sub == 2'b10);
            cyc(e, rt(), sub, rf(), "misc");
            if (sub == 2'b10) begin
                e = '0; e.operation = 3'b010; e.resultRegEn = 1'b1;
                e.CEn = 1'b1; e.ZEn = 1'b1; e.NEn = 1'b1;
                cyc(e, rt(), rj(), fl, "inc_ex");
                mz = fl[1];
                mn = fl[0];
                e = '0; e.selData = 2'b01; e.enb = 1'b1;
                cyc(e, rt(), rj(), rf(), "inc_wb");
            end
            halt_o = (sub == 2'b01) || (sub == 2'b11 && TRAP);
        end
        mrc = mrc + 16'd1;
    endtask

    always @(negedge clk) begin
        cyc_n <= cyc_n + 1;
        if (exp_q.size() > 0) begin
            mon_x = exp_q.pop_front();
            checks++;
            if (act !== mon_x.o) begin
                failures++;
                $display("FAIL %s cycle=%0d got=%h want=%h", mon_x.tag, cyc_n, act, mon_x.o);
            end
`ifdef CU_RETIRE_CNT_EN
            checks++;
            if (retireCount !== mon_x.rc) begin
                failures++;
                $display("FAIL retire_%s cycle=%0d got=%0d want=%0d", mon_x.tag, cyc_n,
                         retireCount, mon_x.rc);
            end
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic [2:0] op;
        logic [1:0] sub;
        reset   = 1'b1;
        toCU    = 4'd0;
        jmpCond = 2'd0;
        {CC, ZZ, NN} = 3'b000;
        mz  = 1'b0;
        mn  = 1'b0;
        mrc = 16'd0;
        do_reset(3);

        exec(3'b000, 2'b00, rf(), h);      // LDA
        exec(3'b010, 2'b00, 3'b101, h);    // ADD: C=1 Z=0 N=1
        exec(3'b110, 2'b00, rf(), h);      // JN taken
        exec(3'b011, 2'b00, 3'b010, h);    // AND: Z=1 N=0
        exec(3'b101, 2'b00, rf(), h);      // JZ taken
        exec(3'b110, 2'b00, rf(), h);      // JN not taken
        exec(3'b001, 2'b00, rf(), h);      // STA
        exec(3'b111, 2'b10, 3'b011, h);    // INC: Z=1 N=1
        exec(3'b111, 2'b00, rf(), h);      // NOP

        // Store interrupted by reset before its write cycle.
        fetch_byte0(3'b001);
        fetch_byte1();
        begin
            outs_t e;
            e = '0; e.dataRegEn = 1'b1;
            cyc(e, rt(), rj(), rf(), "st_rd_abort");
        end
        do_reset(2);
        exec(3'b101, 2'b00, rf(), h);      // JZ after reset: flags cleared, not taken

        exec(3'b111, 2'b01, rf(), h);      // HLT
        hold_halt(20);
        do_reset(3);
        exec(3'b111, 2'b11, rf(), h);      // reserved sub-op traps
        hold_halt(5);
        do_reset(3);

        for (int i = 0; i < 300; i++) begin
            op  = 3'($urandom_range(7));
            sub = 2'($urandom_range(3));
            if (op == 3'b111 && sub[0] && $urandom_range(3) != 0) sub = 2'b00;
            exec(op, sub, rf(), h);
            if (h) begin
                hold_halt($urandom_range(1, 6));
                do_reset($urandom_range(1, 3));
            end else if ($urandom_range(40) == 0) begin
                do_reset($urandom_range(1, 3));
            end
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Multi-cycle Moore controller that drives the accumulator CPU datapath. It sits directly upstream of the datapath and is its only source of control strobes.
- It consumes the datapath's opcode nibble (toCU), condition field (jmpCond) and ALU flag outputs (CC/ZZ/NN).
- It sequences fetch, decode and execute for a 3-bit-opcode ISA over 13-bit addresses and four 8-bit accumulators.

Parameters:
- TRAP_RESERVED, 0, 1 = reserved misc sub-op halts; 0 = reserved sub-op executes as NOP.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- toCU  in  4  memory output byte [7:4]; opcode = toCU[3:1].
- jmpCond  in  2  DI[2:1]; misc sub-op.
- CC, ZZ, NN  in  1 each  combinational ALU carry, zero and negative.
- pcEn, selPC, selAddress, mr, mw, LSEn, RSEn, DIEn, wordRegEn, selALUsrc, enb, dataRegEn, resultRegEn, CEn, ZEn, NEn  out  1 each  datapath strobes.
- selAddressAC  out  2  accumulator index source; 00 = DI[4:3].
- selData  out  2  accumulator write data: 00 = memory word, 01 = result register, 10 = data register.
- operation  out  3  ALU function.
- halted  out  1  high while in HALT.

Behaviour:
- Instruction format:
  - byte0[7:5] = op; byte0[4:3] = accumulator index (AC); byte0[2:1] = sub-op.
  - Memory-reference address = {byte0[4:0], byte1}. AC index therefore equals address[12:11].
- Opcodes:
  - 000 LDA: AC <- M
  - 001 STA: M <- AC
  - 010 ADD: AC <- AC + M; updates C, Z, N
  - 011 AND: AC <- AC & M; updates Z, N
  - 100 JMP
  - 101 JZ
  - 110 JN
  - 111 MISC (single byte); sub-op 00 NOP, 01 HLT, 10 INC AC (updates C, Z, N), 11 reserved.
- Outputs are a pure function of state. Any strobe not listed for a state is 0.
- Outputs are registered only through the state register. selAddressAC = 00 in every state.
- States and assertions:
  - RST: all outputs 0. Next state FETCH0.
  - FETCH0: selAddress=0, mr, LSEn, pcEn, selPC=0. Internal op register <= toCU[3:1]. Next DECODE.
  - DECODE: DIEn. op=111 -> MISC; otherwise FETCH1.
  - FETCH1: selAddress=0, mr, RSEn, pcEn, selPC=0. Next by op: LD, ST_RD, ALU_RD, or JUMP.
  - LD: selAddress=1, mr, selData=00, enb. Next FETCH0.
  - ST_RD: dataRegEn. Next ST_WR.
  - ST_WR: selAddress=1, mw. Next FETCH0.
  - ALU_RD: selAddress=1, mr, selALUsrc=1, operation=ADD/AND, resultRegEn, flag enables per opcode. Next ALU_WB.
  - ALU_WB: selData=01, enb. Next FETCH0.
  - JUMP: selPC=1; pcEn = taken. JMP is always taken; JZ is taken if zf; JN is taken if nf. Next FETCH0.
  - MISC (DI now valid):
    - NOP -> FETCH0.
    - HLT -> HALT.
    - INC: dataRegEn -> INC_EX.
    - Reserved: HALT if TRAP_RESERVED, else FETCH0.
  - INC_EX: selALUsrc=0, operation=INC, resultRegEn, CEn, ZEn, NEn. Next ALU_WB.
  - HALT: halted=1, no strobes. Stays in HALT until reset.
- Internal flags cf, zf, nf:
  - Each samples CC/ZZ/NN on the edge ending any cycle where its CEn/ZEn/NEn is high.
  - All reset to 0.
  - Branches test the internal copies only, never the live ZZ/NN.
- ALU function codes: ADD=000, AND=001, INC=010 (INC = inputA+1).
- Latency in cycles, FETCH0 through return to FETCH0:
  - LDA 4; STA 5; ADD/AND 5; JMP/JZ/JN 4 (taken or not); NOP 3; INC 5; HLT 3 to reach HALT.
- Not-taken branch: PC has already advanced twice, so execution falls through to the next instruction.
- Reset in any state, including mid-execute or HALT: next state RST and flags cleared. A half-finished store never issues mw.
- wordRegEn is tied 0 (unused).

Optional Feature:
- Macro CU_RETIRE_CNT_EN.
- Defined:
  - Adds output retireCount[15:0], reset to 0.
  - Increments by 1 on every transition into FETCH0 from an execute state, and on entry to HALT. It does not increment on RST -> FETCH0.
  - Wraps FFFF -> 0000.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum;
  - opcode constants OP_LDA..OP_MISC;
  - sub-op constants SUB_NOP, SUB_HLT, SUB_INC, SUB_RSV;
  - ALU codes ALU_ADD, ALU_AND, ALU_INC;
  - selData and selAddressAC codes.
- One sub-module, cpu_ctrl_flags: the three flag flops with per-flag enables and synchronous reset.
- Next-state and output decode stay in the top module.

Test Plan:
- Reset held 3 cycles then released:
  - outputs all 0 during reset;
  - FETCH0 on the first cycle after RST with mr=1, LSEn=1, pcEn=1.
- LDA (toCU=0000, then DI valid):
  - exactly 4 cycles;
  - LD cycle has selAddress=1, selData=00, enb=1;
  - no mw anywhere.
- ADD with CC=1, ZZ=0, NN=1 during ALU_RD:
  - CEn/ZEn/NEn high in that cycle only;
  - next cycle ALU_WB with selData=01, enb=1;
  - cf=1, nf=1, zf=0 afterwards.
- AND with ZZ=1, then JZ:
  - JUMP state has pcEn=1, selPC=1.
- JN with nf=0:
  - JUMP state has pcEn=0;
  - FETCH0 follows on the next cycle.
- MISC with jmpCond=01:
  - HALT reached after 3 cycles and halted=1 held for 20 cycles;
  - reset returns to FETCH0.
- Reserved sub-op with TRAP_RESERVED=1:
  - halted=1.
- With CU_RETIRE_CNT_EN defined:
  - 5 instructions -> retireCount=5.
